// File: rtl/mem_bus_responder.sv
// Registered memory-port responder: decodes IM / DM / MMIO regions,
// reports access faults and returns data over a valid/ready handshake.
module mem_bus_responder #(
  parameter int unsigned DM_AW     = 13,
  parameter logic [63:0] MMIO_BASE = 64'h0000_0000_0001_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [63:0]      req_addr,
  input  logic [63:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [61:0]      im_addr,
  input  logic [31:0]      im_rdata,
  output logic [DM_AW-1:0] dm_addr,
  output logic             dm_we,
  output logic [63:0]      dm_wdata,
  input  logic [63:0]      dm_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [63:0] cap_addr;
  logic [63:0] cap_wdata;
  logic        cap_we;

  logic [63:0] cycle_q;
  logic [63:0] scratch_q;
  logic [63:0] fault_addr_q;
  logic [63:0] fault_cnt_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic [63:0] mmio_off;
  logic        hit_im;
  logic        hit_dm;
  logic        hit_mmio;
  logic        fault;
  logic        dm_wr;
  logic        scr_wr;
  logic [63:0] rd_val;

  assign mmio_off = cap_addr - MMIO_BASE;
  assign hit_im   = (cap_addr >> DM_AW) == 64'd0;
  assign hit_dm   = (cap_addr >> DM_AW) == 64'd1;
  assign hit_mmio = (cap_addr >= MMIO_BASE) && (mmio_off < 64'd32);

  always_comb begin
    fault  = 1'b0;
    rd_val = '0;
    unique case (1'b1)
      hit_im: begin
        fault  = cap_we || (cap_addr[1:0] != 2'b00);
        rd_val = {32'b0, im_rdata};
      end
      hit_dm: begin
        fault  = cap_addr[2:0] != 3'b000;
        rd_val = dm_rdata;
      end
      hit_mmio: begin
        // only SCRATCH (offset 0x08) accepts stores
        fault = (cap_addr[2:0] != 3'b000) ||
                (cap_we && (mmio_off[4:3] != 2'd1));
        case (mmio_off[4:3])
          2'd0:    rd_val = cycle_q;
          2'd1:    rd_val = scratch_q;
          2'd2:    rd_val = fault_addr_q;
          default: rd_val = fault_cnt_q;
        endcase
      end
      default: fault = 1'b1;
    endcase
  end

  assign dm_wr  = hit_dm && cap_we && !fault;
  assign scr_wr = hit_mmio && cap_we && !fault;

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    dm_we     = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_valid) state_nx = ACCESS;
      end
      ACCESS: begin
        dm_we    = dm_wr && !reset;
        state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      cap_we       <= 1'b0;
      cycle_q      <= '0;
      scratch_q    <= '0;
      fault_addr_q <= '0;
      fault_cnt_q  <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state   <= state_nx;
      cycle_q <= cycle_q + 64'd1;
      if (state == IDLE && req_valid) begin
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_we    <= req_we;
      end
      if (state == ACCESS) begin
        rdata_q <= (fault || cap_we) ? 64'd0 : rd_val;
        err_q   <= fault;
        if (scr_wr) scratch_q <= cap_wdata;
        if (fault) begin
          fault_addr_q <= cap_addr;
          fault_cnt_q  <= fault_cnt_q + 64'd1;
        end
      end
    end
  end

  assign im_addr   = cap_addr[63:2];
  assign dm_addr   = cap_addr[DM_AW-1:0];
  assign dm_wdata  = cap_wdata;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
